// File: rtl/ssc_sched_pkg.sv
// Shared constants and types for the correlation-readout scheduler.
// Optional build macro SSC_SCHED_TSTAMP_EN adds a 32-bit grant timestamp
// to every result record.
package ssc_sched_pkg;

    localparam logic [15:0] CORR_BASE_DEF = 16'h0600;

    // Register offsets inside one channel's correlation block
    localparam logic [3:0] OFF_CNT  = 4'h0;
    localparam logic [3:0] OFF_LO   = 4'h4;
    localparam logic [3:0] OFF_HI   = 4'h8;
    localparam logic [3:0] OFF_STAT = 4'hC;

    // Scheduler states
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_CNT  = 3'd1;
    localparam logic [2:0] S_RD_LO   = 3'd2;
    localparam logic [2:0] S_RD_HI   = 3'd3;
    localparam logic [2:0] S_RD_STAT = 3'd4;
    localparam logic [2:0] S_PUSH    = 3'd5;
    localparam logic [2:0] S_HOLD    = 3'd6;

    // One correlation result as stored in the record FIFO
    typedef struct packed {
`ifdef SSC_SCHED_TSTAMP_EN
        logic [31:0] tstamp;
`endif
        logic [2:0]  chan;
        logic [31:0] cnt;
        logic [31:0] high;
        logic [31:0] low;
    } rec_t;

    localparam int REC_W = $bits(rec_t);

    // Base address of channel ch's correlation block (stride 0x10)
    function automatic logic [15:0] chan_base(input logic [15:0] base, input logic [2:0] ch);
        return base + {9'd0, ch, 4'd0};
    endfunction

endpackage

// File: rtl/ssc_rec_fifo.sv
// Synchronous record FIFO. Pointers carry one extra wrap bit so that
// full and empty are told apart without a separate occupancy counter.
// Push while full and pop while empty are ignored.
module ssc_rec_fifo #(
    parameter int W     = 99,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         do_push, do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rptr[AW-1:0]];

    // Storage array; contents need no reset since empty gates the head
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr[AW-1:0]] <= din;
    end

    // Read/write pointers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/ssc_corr_sched.sv
// Correlation-readout scheduler: round-robin grant over the channels'
// cseen flags, reads Cnt/Low/High/Status of the granted channel over the
// shared bus, and queues one record per genuine correlation.
// Optional build macro SSC_SCHED_TSTAMP_EN adds rec_tstamp and a
// free-running cycle counter sampled at grant.
module ssc_corr_sched
    import ssc_sched_pkg::*;
#(
    parameter int          NCH       = 8,
    parameter int          FDEPTH    = 8,
    parameter logic [15:0] CORR_BASE = CORR_BASE_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           enable,
    input  logic [NCH-1:0] cseen,
    output logic [31:0]    addr,
    output logic           read,
    output logic           write,
    input  logic [31:0]    Rdata,
    output logic           rec_valid,
    input  logic           rec_ready,
    output logic [2:0]     rec_chan,
    output logic [31:0]    rec_cnt,
    output logic [63:0]    rec_corr,
`ifdef SSC_SCHED_TSTAMP_EN
    output logic [31:0]    rec_tstamp,
`endif
    output logic           busy,
    output logic [15:0]    ovf_cnt
);
    logic [2:0]  state, ptr, chan;
    logic [31:0] cnt_q, lo_q, hi_q;
    logic        stat_q;

    // Round-robin scan signals
    logic [2*NCH-1:0] dbl, shf;
    logic [NCH-1:0]   rot;
    logic [2:0]       start;
    logic [3:0]       off, sum;
    logic [2:0]       grant_idx;
    logic             any_req;

    // FIFO interface
    logic             fifo_full, fifo_empty, fifo_push;
    logic [REC_W-1:0] fifo_din, fifo_dout;
    rec_t             rec_in, head;

    logic [3:0]       reg_off;

`ifdef SSC_SCHED_TSTAMP_EN
    logic [31:0] tcnt, tstamp_q;

    // Free-running cycle counter, wraps
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) tcnt <= '0;
        else      tcnt <= tcnt + 32'd1;
    end
`endif

    // Rotate the request vector so bit 0 is the channel after the pointer,
    // then pick the lowest set bit and map it back to a channel number
    always_comb begin
        start   = (ptr == 3'(NCH-1)) ? 3'd0 : ptr + 3'd1;
        dbl     = {cseen, cseen};
        shf     = dbl >> start;
        rot     = shf[NCH-1:0];
        any_req = |cseen;
        off     = '0;
        for (int j = NCH-1; j >= 0; j--) begin
            if (rot[j]) off = 4'(j);
        end
        sum       = {1'b0, start} + off;
        grant_idx = (sum >= 4'(NCH)) ? 3'(sum - 4'(NCH)) : sum[2:0];
    end

    // Sequencer: grant, four back-to-back reads, push, settle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            ptr     <= 3'(NCH-1);
            chan    <= '0;
            cnt_q   <= '0;
            lo_q    <= '0;
            hi_q    <= '0;
            stat_q  <= 1'b0;
            ovf_cnt <= '0;
`ifdef SSC_SCHED_TSTAMP_EN
            tstamp_q <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (enable && any_req) begin
                        // The slot is reserved here: nothing else pushes
                        // before this sequence reaches PUSH
                        if (!fifo_full) begin
                            chan  <= grant_idx;
                            ptr   <= grant_idx;
                            state <= S_RD_CNT;
`ifdef SSC_SCHED_TSTAMP_EN
                            tstamp_q <= tcnt;
`endif
                        end else if (ovf_cnt != 16'hFFFF) begin
                            ovf_cnt <= ovf_cnt + 16'd1;
                        end
                    end
                end
                S_RD_CNT:  begin cnt_q  <= Rdata;    state <= S_RD_LO;   end
                S_RD_LO:   begin lo_q   <= Rdata;    state <= S_RD_HI;   end
                S_RD_HI:   begin hi_q   <= Rdata;    state <= S_RD_STAT; end
                S_RD_STAT: begin stat_q <= Rdata[0]; state <= S_PUSH;    end
                // HOLD gives the cleared flag a cycle to drop before rescan
                S_PUSH:    state <= S_HOLD;
                S_HOLD:    state <= S_IDLE;
                default:   state <= S_IDLE;
            endcase
        end
    end

    // Bus address/strobe decoded from state; zero outside the read states
    always_comb begin
        read    = 1'b1;
        reg_off = OFF_CNT;
        case (state)
            S_RD_CNT:  reg_off = OFF_CNT;
            S_RD_LO:   reg_off = OFF_LO;
            S_RD_HI:   reg_off = OFF_HI;
            S_RD_STAT: reg_off = OFF_STAT;
            default:   read    = 1'b0;
        endcase
        addr = read ? {16'd0, chan_base(CORR_BASE, chan) + {12'd0, reg_off}} : 32'd0;
    end

    assign write = 1'b0;
    assign busy  = (state != S_IDLE);

    // Record assembly; a clear Status bit means the flag was spurious
    always_comb begin
        rec_in      = '0;
        rec_in.chan = chan;
        rec_in.cnt  = cnt_q;
        rec_in.high = hi_q;
        rec_in.low  = lo_q;
`ifdef SSC_SCHED_TSTAMP_EN
        rec_in.tstamp = tstamp_q;
`endif
    end

    assign fifo_push = (state == S_PUSH) && stat_q;
    assign fifo_din  = rec_in;

    ssc_rec_fifo #(.W(REC_W), .DEPTH(FDEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (rec_ready),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Head outputs read as zero while the FIFO is empty
    assign head      = fifo_empty ? '0 : rec_t'(fifo_dout);
    assign rec_valid = !fifo_empty;
    assign rec_chan  = head.chan;
    assign rec_cnt   = head.cnt;
    assign rec_corr  = {head.high, head.low};
`ifdef SSC_SCHED_TSTAMP_EN
    assign rec_tstamp = head.tstamp;
`endif

endmodule

// File: tb/tb_ssc_corr_sched.sv
// Scoreboard bench for ssc_corr_sched: stimulus pushes expected bus reads
// and records into queues; two monitors pop and compare on the falling edge.
module tb_ssc_corr_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  cseen_r = '0;
    logic [7:0]  set_req = '0;
    logic [7:0]  clr;
    logic [7:0]  stat_zero = '0;
    logic [31:0] addr, Rdata;
    logic        read, write, rec_valid, busy;
    logic        rec_ready = 1'b1;
    logic [2:0]  rec_chan;
    logic [31:0] rec_cnt;
    logic [63:0] rec_corr;
    logic [15:0] ovf_cnt;
`ifdef SSC_SCHED_TSTAMP_EN
    logic [31:0] rec_tstamp;
`endif

    logic [31:0] m_cnt [8];
    logic [31:0] m_lo  [8];
    logic [31:0] m_hi  [8];

    typedef struct {
        logic [2:0]  chan;
        logic [31:0] cnt;
        logic [63:0] corr;
    } exp_t;

    logic [31:0] exp_addr[$];
    exp_t        exp_rec[$];
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ssc_corr_sched #(.NCH(8), .FDEPTH(2), .CORR_BASE(16'h0600)) dut (
        .clk(clk), .rst(rst), .enable(enable), .cseen(cseen_r),
        .addr(addr), .read(read), .write(write), .Rdata(Rdata),
        .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_chan(rec_chan),
        .rec_cnt(rec_cnt), .rec_corr(rec_corr),
`ifdef SSC_SCHED_TSTAMP_EN
        .rec_tstamp(rec_tstamp),
`endif
        .busy(busy), .ovf_cnt(ovf_cnt)
    );

    // Channel register model: combinational read data, Status read clears flag
    always_comb begin
        Rdata = '0;
        clr   = '0;
        if (read && addr[31:8] == 24'h000006 && !addr[7]) begin
            case (addr[3:0])
                4'h0: Rdata = m_cnt[addr[6:4]];
                4'h4: Rdata = m_lo[addr[6:4]];
                4'h8: Rdata = m_hi[addr[6:4]];
                4'hC: begin
                    Rdata = {31'd0, cseen_r[addr[6:4]] & ~stat_zero[addr[6:4]]};
                    clr   = 8'd1 << addr[6:4];
                end
                default: Rdata = '0;
            endcase
        end
    end

    always @(posedge clk) cseen_r <= (cseen_r | set_req) & ~clr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Bus monitor
    always @(negedge clk) begin
        if (rst && read) begin
            if (exp_addr.size() == 0) chk("unexpected_read", addr, 0);
            else chk("bus_addr", addr, exp_addr.pop_front());
            chk("write_tied", write, 0);
        end
    end

    // Record monitor
    always @(negedge clk) begin
        if (rst && rec_valid && rec_ready) begin
            if (exp_rec.size() == 0) chk("unexpected_rec", rec_chan, 7'h7f);
            else begin
                exp_t e;
                e = exp_rec.pop_front();
                chk("rec_chan", rec_chan, e.chan);
                chk("rec_cnt", rec_cnt, e.cnt);
                chk("rec_corr", rec_corr, e.corr);
            end
        end
    end

    task automatic exp_seq(input int k, input bit ok);
        exp_t e;
        for (int o = 0; o < 4; o++) exp_addr.push_back(32'h600 + 32'(k) * 32'h10 + 32'(o) * 4);
        e.chan = 3'(k);
        e.cnt  = m_cnt[k];
        e.corr = {m_hi[k], m_lo[k]};
        if (ok) exp_rec.push_back(e);
    endtask

    task automatic raise(input logic [7:0] m);
        set_req = m;
        @(posedge clk);
        #1 set_req = '0;
    endtask

    // Wait until expected traffic is consumed and the scheduler is idle
    task automatic run_quiet(input string nm, input bit with_rec, input int budget);
        int n = 0;
        while ((exp_addr.size() != 0 || (with_rec && exp_rec.size() != 0) || busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_done_in_budget"}, n < budget, 1);
    endtask

    initial begin
        logic [15:0] ov0;
        int n;
        for (int k = 0; k < 8; k++) begin
            m_cnt[k] = 32'h100 + k;
            m_lo[k]  = 32'hA000_0000 + k;
            m_hi[k]  = 32'h5000_0000 + k;
        end
        m_cnt[6] = 32'h10;
        m_lo[6]  = 32'hDEAD_BEEF;
        m_hi[6]  = 32'hFFFF_FFFF;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_addr", addr, 0);
        chk("rst_read", read, 0);
        chk("rst_write", write, 0);
        chk("rst_valid", rec_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf_cnt, 0);
        chk("rst_corr", rec_corr, 0);
        @(posedge clk); #1 rst = 1'b1;

        // enable low: flag pending but no reads
        raise(8'h04);
        repeat (8) @(negedge clk);
        chk("en0_busy", busy, 0);
        chk("en0_flag_held", cseen_r[2], 1);
        exp_seq(2, 1);
        @(posedge clk); #1 enable = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("en1_grant_next_cycle", busy, 1);
        run_quiet("ch2", 1, 40);

        // Channel 6 full sequence
        exp_seq(6, 1);
        @(posedge clk); #1;
        raise(8'h40);
        run_quiet("ch6", 1, 40);
        chk("ch6_flag_cleared", cseen_r[6], 0);

        // Round robin: park pointer on 7, then 0 and 7 together
        exp_seq(7, 1);
        @(posedge clk); #1; raise(8'h80);
        run_quiet("rr_park7", 1, 40);
        exp_seq(0, 1); exp_seq(7, 1);
        @(posedge clk); #1; raise(8'h81);
        run_quiet("rr_round1", 1, 60);
        exp_seq(0, 1);
        @(posedge clk); #1; raise(8'h01);
        run_quiet("rr_park0", 1, 40);
        exp_seq(7, 1); exp_seq(0, 1);
        @(posedge clk); #1; raise(8'h81);
        run_quiet("rr_round2", 1, 60);

        // Spurious flag: Status reads 0, nothing queued
        stat_zero = 8'h08;
        exp_seq(3, 0);
        @(posedge clk); #1; raise(8'h08);
        run_quiet("spurious", 1, 40);
        chk("spur_no_rec", rec_valid, 0);
        chk("spur_flag_cleared", cseen_r[3], 0);
        stat_zero = '0;

        // FIFO full: depth 2, consumer stalled, channels 1,4,5 flagged
        @(posedge clk); #1 rec_ready = 1'b0;
        exp_seq(4, 1); exp_seq(5, 1);
        raise(8'h32);
        n = 0;
        while ((exp_addr.size() != 0 || busy) && n < 60) begin @(negedge clk); n++; end
        chk("full_two_served", n < 60, 1);
        ov0 = ovf_cnt;
        chk("full_ovf_start", ov0, 0);
        repeat (3) @(negedge clk);
        chk("full_ovf_3", ovf_cnt, 3);
        chk("full_ch1_held", cseen_r[1], 1);
        chk("full_stall_head", rec_chan, 4);
        chk("full_idle", busy, 0);
        exp_seq(1, 1);
        @(posedge clk); #1 rec_ready = 1'b1;
        run_quiet("drain", 1, 60);
        chk("drain_ch1_cleared", cseen_r[1], 0);

        // Reset during RD_HI of channel 6, then full re-read
        exp_addr.push_back(32'h660); exp_addr.push_back(32'h664); exp_addr.push_back(32'h668);
        @(posedge clk); #1; raise(8'h40);
        n = 0;
        do begin @(negedge clk); n++; end while (!(read && addr == 32'h668) && n < 20);
        chk("rst_mid_reached_hi", n < 20, 1);
        #2 rst = 1'b0;
        #1;
        chk("rstmid_read", read, 0);
        chk("rstmid_addr", addr, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ovf", ovf_cnt, 0);
        chk("rstmid_flag_kept", cseen_r[6], 1);
        exp_seq(6, 1);
        @(posedge clk); #1 rst = 1'b1;
        run_quiet("rstmid_reread", 1, 40);
        chk("rstmid_flag_cleared", cseen_r[6], 0);

        repeat (4) @(negedge clk);
        chk("final_addr_q_empty", exp_addr.size(), 0);
        chk("final_rec_q_empty", exp_rec.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ssc_corr_sched.md
Name: ssc_corr_sched

Overview:
- Correlation-readout scheduler for the NCH spread-spectrum correlator channels (ssc0..ssc7) sharing one register bus.
- Watches each channel's cseen flag and grants channels round-robin.
- For the granted channel, sequences bus reads of Cnt/Low/High/Status; the Status read clears that channel's flag.
- Pushes one result record per correlation into an internal FIFO drained by the host/DMA side.

Parameters:
- NCH, 8, number of correlator channels (1..8)
- FDEPTH, 8, record FIFO depth (power of two, >=2)
- CORR_BASE, 16'h0600, address of channel 0 Correlation Cnt register; channel k base = CORR_BASE + 16'h10*k

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-low
- enable  in  1  scheduler run; when 0 no new grant is issued (an in-flight sequence completes)
- cseen  in  NCH  per-channel correlation-seen flags (cseen0..cseenN-1)
- addr  out  32  bus address; upper 16 bits always 0
- read  out  1  bus read strobe
- write  out  1  bus write strobe, tied 0 (reserved)
- Rdata  in  32  OR of channel Rdata outputs, valid combinationally in the same cycle as read
- rec_valid  out  1  FIFO head valid
- rec_ready  in  1  consumer accepts head when rec_valid&rec_ready
- rec_chan  out  3  channel number of head record
- rec_cnt  out  32  Correlation Cnt of head record
- rec_corr  out  64  {High,Low} correlation of head record
- busy  out  1  sequence in progress (state != IDLE)
- ovf_cnt  out  16  count of grants deferred because FIFO was full, saturating

Behaviour:
- Reset (rst=0, async): state IDLE, addr=0, read=0, write=0, rec_valid=0, rec_* =0, busy=0, ovf_cnt=0, round-robin pointer=NCH-1, FIFO empty. Reset mid-sequence abandons it; the channel's flag stays set and is serviced after reset.
- States: IDLE -> RD_CNT -> RD_LO -> RD_HI -> RD_STAT -> PUSH -> HOLD -> IDLE.
- IDLE: if enable and any cseen bit set and FIFO not full: grant the first set bit scanning from pointer+1 (mod NCH); pointer<=granted; go RD_CNT. If any cseen set but FIFO full: ovf_cnt+1 once per IDLE cycle (saturate at 16'hFFFF), no grant.
- RD_CNT/RD_LO/RD_HI: read=1, addr = base+0/+4/+8; Rdata captured at the end of that cycle into cnt/low/high staging. One cycle each, no wait states.
- RD_STAT: read=1, addr=base+C; captures Status[0]. Addresses are strictly distinct in consecutive cycles, so the channel's first-read status clear fires.
- PUSH: if captured Status[0]==1, write {chan,cnt,high,low} to FIFO; else discard (spurious flag) without pushing. read=0, addr=0.
- HOLD: one cycle to let the cleared cseen settle before re-arbitration, so the same channel is not regranted on a stale flag.
- Total: 6 cycles grant-to-IDLE; record visible at rec_valid the cycle after PUSH when FIFO was empty.
- FIFO: full/empty via pointers with an extra wrap bit; push and pop in the same cycle when full is legal only because push never occurs when full (checked at grant, FIFO slot reserved). Simultaneous push and pop when nonempty: occupancy unchanged. rec_* drive FIFO head combinationally; hold stable while rec_valid & !rec_ready.
- enable deasserted mid-sequence: sequence finishes, then stays IDLE.
- read is never asserted outside RD_* states; write is constant 0.

Optional Feature:
- SSC_SCHED_TSTAMP_EN: adds a 32-bit free-running cycle counter (reset 0, wraps) and output port rec_tstamp[31:0]; the counter value at grant is stored with each record. Without the macro, neither the port nor the counter exists; the record width is 99 bits.

Decomposition:
- Package ssc_sched_pkg: state enum, register offsets (OFF_CNT=0, OFF_LO=4, OFF_HI=8, OFF_STAT=C), record struct/width constant, CORR_BASE default.
- Sub-module ssc_rec_fifo: a parameterised synchronous FIFO (width, depth) with push/pop/full/empty; the scheduler instantiates it once.

Test Plan:
- Channel-6 model with Cnt=0x10, Low=0xDEADBEEF, High=0xFFFFFFFF, cseen[6] pulse -> reads at 0x660,0x664,0x668,0x66C on consecutive cycles; record chan=6, cnt=0x10, corr=0xFFFFFFFF_DEADBEEF; cseen[6] clears.
- cseen=8'b1000_0001 with pointer=7 -> channel 0 served first, then channel 7; second round serves 7 then 0 when both are raised again.
- FDEPTH=2, rec_ready=0, three channels flagged -> two records queued, third channel held with flag set; ovf_cnt increments each IDLE cycle; raising rec_ready drains and the third is then served.
- Status model returns 0 on the 0x66C read -> no push, FIFO unchanged, scheduler returns to IDLE.
- rst driven low during RD_HI -> outputs go to reset values immediately; after release the same channel is fully re-read and one record results.
- enable=0 with cseen set -> no read strobes; enable=1 -> grant on the next IDLE cycle.
